// File: rtl/ahb_reg_slave_pkg.sv
// Shared types and helpers for the AHB scratch-register responder.
// Byte-lane merge is kept here so the write path and read forwarding use one definition.
package ahb_reg_slave_pkg;

    localparam int DATA_W = 32;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [3:0]        strb
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ahb_byte_strobe.sv
// Maps AHB transfer size and low address bits to little-endian byte strobes; purely combinational.
// No backpressure; sizes above a word yield no strobes and are left to the caller to reject.
`include "amba_ahb_h.v"

module ahb_byte_strobe (
    input  logic [2:0] hsize,
    input  logic [1:0] haddr_lo,
    output logic [3:0] strb,
    output logic       misalign
);

    always_comb begin
        strb     = 4'b0000;
        misalign = 1'b0;
        case (hsize)
            `HSIZE_BYTE: strb = 4'b0001 << haddr_lo;
            `HSIZE_HALF: begin
                strb     = haddr_lo[1] ? 4'b1100 : 4'b0011;
                misalign = haddr_lo[0];
            end
            `HSIZE_WORD: begin
                strb     = 4'b1111;
                misalign = |haddr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/amba_ahb_h.v
// Shared AMBA AHB-Lite constants used by every bus responder on the shared AHB bus.
`ifndef AMBA_AHB_H
`define AMBA_AHB_H

`define W_BURST       3

`define HTRANS_IDLE   2'b00
`define HTRANS_BUSY   2'b01
`define HTRANS_NONSEQ 2'b10
`define HTRANS_SEQ    2'b11

`define HRESP_OKAY    2'b00
`define HRESP_ERROR   2'b01
`define HRESP_RETRY   2'b10
`define HRESP_SPLIT   2'b11

`define HSIZE_BYTE    3'b000
`define HSIZE_HALF    3'b001
`define HSIZE_WORD    3'b010

`endif

// File: rtl/ahb_reg_slave.sv
// AHB-Lite scratch-register responder; OKAY transfers take P_WAIT+1 data-phase cycles, errors take two.
// Stalls the bus with HREADY low during wait states and the first ERROR cycle.
`include "amba_ahb_h.v"

module ahb_reg_slave
    import ahb_reg_slave_pkg::*;
#(
    parameter int P_NUM_REGS = 16,
    parameter int P_WAIT     = 2
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                sl_HSEL,
    input  logic                sl_HREADY,
    input  logic [1:0]          sl_HTRANS,
    input  logic [`W_BURST-1:0] sl_HBURST,
    input  logic [2:0]          sl_HSIZE,
    input  logic [31:0]         sl_HADDR,
    input  logic                sl_HWRITE,
    input  logic [31:0]         sl_HWDATA,
    output logic                out_sl_HREADY,
    output logic [1:0]          out_sl_HRESP,
    output logic [31:0]         out_sl_HRDATA
);

    localparam int          IDX_W      = $clog2(P_NUM_REGS);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * P_NUM_REGS);
    localparam logic [2:0]  WAIT_INIT  = (P_WAIT > 0) ? 3'(P_WAIT - 1) : 3'd0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_LAST = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    localparam state_t S_LEGAL = (P_WAIT > 0) ? S_WAIT : S_LAST;

    state_t            state, state_nxt;
    logic [2:0]        wait_cnt;
    logic [IDX_W-1:0]  a_idx;
    logic [3:0]        a_strb;
    logic              a_write;
    logic [DATA_W-1:0] regs [P_NUM_REGS];

    logic              accept, xfer_err, commit, misalign;
    logic [3:0]        strb;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_word;
    logic              unused_ok;

    assign unused_ok = ^{sl_HBURST, sl_HTRANS[0]};

    ahb_byte_strobe u_strobe (
        .hsize    (sl_HSIZE),
        .haddr_lo (sl_HADDR[1:0]),
        .strb     (strb),
        .misalign (misalign)
    );

    // Address phase is only looked at when the previous data phase is in its final cycle.
    assign accept   = sl_HSEL && sl_HREADY && sl_HTRANS[1]
                      && (state inside {S_IDLE, S_LAST, S_ERR2});
    assign xfer_err = (sl_HADDR >= ADDR_LIMIT) || (sl_HSIZE > `HSIZE_WORD) || misalign;
    assign commit   = (state == S_LAST) && a_write;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_LAST, S_ERR2: begin
                if (accept) begin
                    state_nxt = xfer_err ? S_ERR1 : S_LEGAL;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 3'd0) begin
                    state_nxt = S_LAST;
                end
            end
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    // With no wait states the read is entered straight from the address phase, possibly while
    // the previous write is committing, so the pending write is forwarded into the read word.
    always_comb begin
        rd_idx  = (state == S_WAIT) ? a_idx : sl_HADDR[IDX_W+1:2];
        rd_word = regs[rd_idx];
        if (commit && (a_idx == rd_idx)) begin
            rd_word = merge_bytes(rd_word, sl_HWDATA, a_strb);
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state         <= S_IDLE;
            wait_cnt      <= 3'd0;
            a_idx         <= '0;
            a_strb        <= 4'b0000;
            a_write       <= 1'b0;
            out_sl_HREADY <= 1'b1;
            out_sl_HRESP  <= `HRESP_OKAY;
            out_sl_HRDATA <= '0;
            for (int i = 0; i < P_NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_idx    <= sl_HADDR[IDX_W+1:2];
                a_strb   <= strb;
                a_write  <= sl_HWRITE;
                wait_cnt <= WAIT_INIT;
            end else if ((state == S_WAIT) && (wait_cnt != 3'd0)) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            out_sl_HREADY <= !(state_nxt inside {S_WAIT, S_ERR1});
            out_sl_HRESP  <= (state_nxt inside {S_ERR1, S_ERR2}) ? `HRESP_ERROR : `HRESP_OKAY;
            out_sl_HRDATA <= (state_nxt == S_LAST) ? rd_word : '0;
            if (commit) begin
                regs[a_idx] <= merge_bytes(regs[a_idx], sl_HWDATA, a_strb);
            end
        end
    end

endmodule

// File: tb/tb_ahb_reg_slave.sv
// Bench for ahb_reg_slave: a pipelined AHB master drives two instances (P_WAIT=2 and P_WAIT=0),
// a register model predicts each response into a scoreboard that is drained as data phases finish.
module tb_ahb_reg_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        use0 = 1'b0;
    logic        hsel = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hburst = 3'b000;
    logic [2:0]  hsize = 3'b010;
    logic [31:0] haddr = 32'h0;
    logic        hwrite = 1'b0;
    logic [31:0] hwdata = 32'h0;

    logic        rdy_w2, rdy_w0;
    logic [1:0]  resp_w2, resp_w0;
    logic [31:0] rdata_w2, rdata_w0;
    logic        bus_rdy;
    logic [1:0]  bus_resp;
    logic [31:0] bus_rdata;

    int n_total = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign bus_rdy   = use0 ? rdy_w0 : rdy_w2;
    assign bus_resp  = use0 ? resp_w0 : resp_w2;
    assign bus_rdata = use0 ? rdata_w0 : rdata_w2;

    ahb_reg_slave #(.P_NUM_REGS(16), .P_WAIT(2)) u_w2 (
        .HCLK(clk), .HRESETn(rst_n), .sl_HSEL(hsel & ~use0), .sl_HREADY(bus_rdy),
        .sl_HTRANS(htrans), .sl_HBURST(hburst), .sl_HSIZE(hsize), .sl_HADDR(haddr),
        .sl_HWRITE(hwrite), .sl_HWDATA(hwdata),
        .out_sl_HREADY(rdy_w2), .out_sl_HRESP(resp_w2), .out_sl_HRDATA(rdata_w2)
    );

    ahb_reg_slave #(.P_NUM_REGS(16), .P_WAIT(0)) u_w0 (
        .HCLK(clk), .HRESETn(rst_n), .sl_HSEL(hsel & use0), .sl_HREADY(bus_rdy),
        .sl_HTRANS(htrans), .sl_HBURST(hburst), .sl_HSIZE(hsize), .sl_HADDR(haddr),
        .sl_HWRITE(hwrite), .sl_HWDATA(hwdata),
        .out_sl_HREADY(rdy_w0), .out_sl_HRESP(resp_w0), .out_sl_HRDATA(rdata_w0)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        logic        wr;
        logic        err;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    xfer_t       xq[$];
    exp_t        sb[$];
    logic [31:0] mreg [2][16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input logic [2:0] size, input logic [31:0] addr);
        return (addr >= 32'd64) || (size > 3'd2)
            || ((size == 3'd1) && addr[0]) || ((size == 3'd2) && (addr[1:0] != 2'b00));
    endfunction

    function automatic void model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 16; r++) begin
                mreg[d][r] = 32'h0;
            end
        end
    endfunction

    function automatic void push(input xfer_t x);
        exp_t e;
        int   idx;
        logic lane;
        if (!(x.sel && x.trans[1])) return;
        idx     = int'(x.addr[5:2]);
        e.wr    = x.wr;
        e.err   = model_err(x.size, x.addr);
        e.waits = e.err ? 1 : (use0 ? 0 : 2);
        e.rdata = 32'h0;
        if (!e.err) begin
            if (x.wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (x.size == 3'd0)      lane = (b == int'(x.addr[1:0]));
                    else if (x.size == 3'd1) lane = ((b / 2) == int'(x.addr[1]));
                    else                     lane = 1'b1;
                    if (lane) mreg[use0][idx][8*b +: 8] = x.wdata[8*b +: 8];
                end
            end else begin
                e.rdata = mreg[use0][idx];
            end
        end
        sb.push_back(e);
    endfunction

    task automatic q(input logic sel, input logic [1:0] trans, input logic wr,
                     input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.wr = wr; x.size = size; x.addr = addr; x.wdata = wdata;
        xq.push_back(x);
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge with the bus idle.
    task automatic run_bus(input int budget);
        xfer_t a, d;
        exp_t  e;
        logic  av = 1'b0, dv = 1'b0, rdy_s;
        int    cyc = 0, wcnt = 0;
        while ((xq.size() > 0 || av || dv) && cyc < budget) begin
            if (!av && xq.size() > 0) begin
                a  = xq.pop_front();
                av = 1'b1;
                push(a);
            end
            hsel   = av ? a.sel : 1'b0;
            htrans = av ? a.trans : 2'b00;
            hwrite = av ? a.wr : 1'b0;
            hsize  = av ? a.size : 3'd2;
            haddr  = av ? a.addr : 32'h0;
            hburst = 3'($urandom_range(0, 7));
            hwdata = (dv && d.wr) ? d.wdata : 32'h0;
            @(negedge clk);
            if (dv && sb.size() > 0) begin
                e = sb[0];
                chk("resp", 32'(bus_resp), e.err ? 32'd1 : 32'd0);
                if (!bus_rdy) begin
                    wcnt++;
                    chk("wait_rdata", bus_rdata, 32'h0);
                end else begin
                    void'(sb.pop_front());
                    chk("waits", 32'(wcnt), 32'(e.waits));
                    if (!e.wr || e.err) chk("rdata", bus_rdata, e.rdata);
                end
            end else begin
                chk("idle_rdy", 32'(bus_rdy), 32'd1);
                chk("idle_resp", 32'(bus_resp), 32'd0);
            end
            rdy_s = bus_rdy;
            @(posedge clk);
            #1;
            cyc++;
            if (rdy_s) begin
                dv = av && a.sel && a.trans[1];
                if (dv) begin
                    d    = a;
                    wcnt = 0;
                end
                av = 1'b0;
            end
        end
        chk("bus_drained", 32'(xq.size()) + 32'(av) + 32'(dv), 32'd0);
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = 32'h0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy_w2", 32'(rdy_w2), 32'd1);
        chk("rst_resp_w2", 32'(resp_w2), 32'd0);
        chk("rst_rdata_w2", rdata_w2, 32'h0);
        chk("rst_rdy_w0", 32'(rdy_w0), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Wait-state instance: read after reset, word/byte merge.
        use0 = 1'b0;
        q(1, 2'b10, 0, 3'd2, 32'h0, 32'h0);
        q(1, 2'b10, 1, 3'd2, 32'h8, 32'hDEADBEEF);
        q(1, 2'b10, 1, 3'd0, 32'hA, 32'h0055_0000);
        q(1, 2'b10, 0, 3'd2, 32'h8, 32'h0);
        run_bus(200);
        chk("merge_const", mreg[0][2], 32'hDE55BEEF);

        // Illegal accesses, then confirm nothing moved.
        q(1, 2'b10, 0, 3'd2, 32'h40, 32'h0);
        q(1, 2'b10, 1, 3'd1, 32'h3, 32'hFFFF_FFFF);
        q(1, 2'b11, 1, 3'd3, 32'h8, 32'h1111_1111);
        q(1, 2'b10, 1, 3'd2, 32'h6, 32'h2222_2222);
        q(1, 2'b10, 0, 3'd2, 32'h8, 32'h0);
        q(1, 2'b10, 0, 3'd2, 32'h0, 32'h0);
        q(1, 2'b10, 1, 3'd1, 32'hE, 32'hA5A5_0000);
        q(1, 2'b11, 0, 3'd2, 32'hC, 32'h0);
        run_bus(200);

        // Zero-wait instance: back-to-back write/read, including a sub-word write then read.
        use0 = 1'b1;
        q(1, 2'b10, 1, 3'd2, 32'h4, 32'h12345678);
        q(1, 2'b10, 0, 3'd2, 32'h4, 32'h0);
        q(1, 2'b11, 1, 3'd1, 32'h6, 32'hCAFE_0000);
        q(1, 2'b11, 0, 3'd2, 32'h4, 32'h0);
        q(1, 2'b10, 1, 3'd0, 32'h3D, 32'h0000_7700);
        q(1, 2'b10, 0, 3'd2, 32'h3C, 32'h0);
        q(1, 2'b10, 0, 3'd1, 32'h3F, 32'h0);
        q(1, 2'b10, 0, 3'd2, 32'h3C, 32'h0);
        run_bus(200);

        // Unselected / IDLE / BUSY traffic must leave everything alone.
        use0 = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) q(0, 2'b10, 1, 3'd2, {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
            else            q(1, (i % 2) ? 2'b01 : 2'b00, 1, 3'd2,
                              {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
        end
        for (int r = 0; r < 16; r++) q(1, 2'b10, 0, 3'd2, 32'(r * 4), 32'h0);
        run_bus(400);

        // Reset during the wait state of a write: write is abandoned.
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h0;
        @(posedge clk);
        #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst_mid_wait_rdy", 32'(rdy_w2), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_rdy", 32'(rdy_w2), 32'd1);
        chk("rst_mid_resp", 32'(resp_w2), 32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        hwdata = 32'h0;
        model_clear();
        q(1, 2'b10, 0, 3'd2, 32'h0, 32'h0);
        q(1, 2'b10, 0, 3'd2, 32'h8, 32'h0);
        run_bus(100);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
